// File: rtl/qdiv_scheduler_if.sv
// qdiv_scheduler_if: operand, divider and result signals of the qdiv scheduler
//   slave  : scheduler side (takes operands, drives the divider, offers results)
//   master : environment side (operand source, divider, result sink)
interface qdiv_scheduler_if #(
    parameter int N = 32
);
    logic         i_op_valid;
    logic         o_op_ready;
    logic [N-1:0] i_dividend;
    logic [N-1:0] i_divisor;
    logic [N-1:0] o_div_dividend;
    logic [N-1:0] o_div_divisor;
    logic         o_div_start;
    logic         i_div_complete;
    logic [N-1:0] i_div_quotient;
    logic         i_div_overflow;
    logic         o_res_valid;
    logic         i_res_ready;
    logic [N-1:0] o_res_quotient;
    logic         o_res_overflow;
    logic         o_res_divzero;
    logic         o_busy;

    modport slave (
        input  i_op_valid, i_dividend, i_divisor,
        input  i_div_complete, i_div_quotient, i_div_overflow,
        input  i_res_ready,
        output o_op_ready, o_div_dividend, o_div_divisor, o_div_start,
        output o_res_valid, o_res_quotient, o_res_overflow, o_res_divzero, o_busy
    );

    modport master (
        output i_op_valid, i_dividend, i_divisor,
        output i_div_complete, i_div_quotient, i_div_overflow,
        output i_res_ready,
        input  o_op_ready, o_div_dividend, o_div_divisor, o_div_start,
        input  o_res_valid, o_res_quotient, o_res_overflow, o_res_divzero, o_busy
    );
endinterface

// File: rtl/qdiv_scheduler.sv
// qdiv_scheduler: queues sign-magnitude operand pairs and feeds them one at a time to qdiv
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus (slave)  : operand valid/ready input, divider start/complete interface,
//                  in-order result valid/ready output with overflow/divzero flags, busy
module qdiv_scheduler #(
    parameter int Q     = 15,
    parameter int N     = 32,
    parameter int DEPTH = 4
) (
    input logic           i_clk,
    input logic           i_rst,
    qdiv_scheduler_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    if (Q >= N - 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
        $error("qdiv_scheduler: invalid Q/N/DEPTH");
    end

    typedef enum logic [2:0] {RESYNC, IDLE, LAUNCH, WAIT_ACK, WAIT_DONE} state_t;

    state_t       state_q, state_d;
    logic [N-1:0] dvd_mem_q [DEPTH];
    logic [N-1:0] dvs_mem_q [DEPTH];
    logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
    logic [N-1:0] div_dvd_q, div_dvd_d, div_dvs_q, div_dvs_d;
    logic         res_valid_q, res_valid_d, res_ovf_q, res_ovf_d, res_dz_q, res_dz_d;
    logic [N-1:0] res_quo_q, res_quo_d;
    logic [N-1:0] head_dvd, head_dvs;
    logic         empty, full, push, pop, head_zero, capture;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty     = wr_q == rd_q;
    assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign push      = bus.i_op_valid && !full;
    assign pop       = state_q == IDLE && !empty && !res_valid_q;
    assign head_dvd  = dvd_mem_q[rd_q[AW-1:0]];
    assign head_dvs  = dvs_mem_q[rd_q[AW-1:0]];
    assign head_zero = head_dvs[N-2:0] == '0;
    assign capture   = state_q == WAIT_DONE && bus.i_div_complete;

    always_ff @(posedge i_clk) begin
        if (push) begin
            dvd_mem_q[wr_q[AW-1:0]] <= bus.i_dividend;
            dvs_mem_q[wr_q[AW-1:0]] <= bus.i_divisor;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= RESYNC;
            wr_q        <= '0;
            rd_q        <= '0;
            div_dvd_q   <= '0;
            div_dvs_q   <= '0;
            res_valid_q <= 1'b0;
            res_quo_q   <= '0;
            res_ovf_q   <= 1'b0;
            res_dz_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            div_dvd_q   <= div_dvd_d;
            div_dvs_q   <= div_dvs_d;
            res_valid_q <= res_valid_d;
            res_quo_q   <= res_quo_d;
            res_ovf_q   <= res_ovf_d;
            res_dz_q    <= res_dz_d;
        end
    end

    // The divider has no reset, so after our reset it may still be running; RESYNC
    // waits for it to finish before any start can be issued.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RESYNC:    state_d = bus.i_div_complete ? IDLE : RESYNC;
            IDLE:      state_d = (pop && !head_zero) ? LAUNCH : IDLE;
            LAUNCH:    state_d = WAIT_ACK;
            WAIT_ACK:  state_d = bus.i_div_complete ? WAIT_ACK : WAIT_DONE;
            WAIT_DONE: state_d = bus.i_div_complete ? IDLE : WAIT_DONE;
            default:   state_d = RESYNC;
        endcase
    end

    // Result register only loads while empty (pop requires it, and nothing else
    // loads it while a division is in flight), so drain and load never collide.
    always_comb begin
        wr_d        = push ? wr_q + (AW+1)'(1) : wr_q;
        rd_d        = pop ? rd_q + (AW+1)'(1) : rd_q;
        div_dvd_d   = (pop && !head_zero) ? head_dvd : div_dvd_q;
        div_dvs_d   = (pop && !head_zero) ? head_dvs : div_dvs_q;
        res_valid_d = res_valid_q;
        res_quo_d   = res_quo_q;
        res_ovf_d   = res_ovf_q;
        res_dz_d    = res_dz_q;
        if (res_valid_q && bus.i_res_ready) begin
            res_valid_d = 1'b0;
            res_quo_d   = '0;
            res_ovf_d   = 1'b0;
            res_dz_d    = 1'b0;
        end else if (pop && head_zero) begin
            res_valid_d = 1'b1;
            res_quo_d   = {head_dvd[N-1] ^ head_dvs[N-1], {(N-1){1'b1}}};
            res_ovf_d   = 1'b1;
            res_dz_d    = 1'b1;
        end else if (capture) begin
            res_valid_d = 1'b1;
            res_quo_d   = bus.i_div_quotient;
            res_ovf_d   = bus.i_div_overflow;
            res_dz_d    = 1'b0;
        end
    end

    always_comb begin
        bus.o_op_ready     = !full;
        bus.o_div_start    = state_q == LAUNCH;
        bus.o_div_dividend = div_dvd_q;
        bus.o_div_divisor  = div_dvs_q;
        bus.o_res_valid    = res_valid_q;
        bus.o_res_quotient = res_quo_q;
        bus.o_res_overflow = res_ovf_q;
        bus.o_res_divzero  = res_dz_q;
        bus.o_busy         = !empty || state_q != IDLE;
    end
endmodule
